// File: rtl/btb_update_ctrl_if.sv
// Bundle between the BTB update controller and its environment: EX branch
// handshake, invalidate control, and the shared single-ported table port.
interface btb_update_ctrl_if #(parameter int ENTRIES = 4);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             ex_ready;
  logic             inv_req;
  logic             inv_busy;
  logic             lookup_active;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_cnt;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       wr_cnt;
  logic [31:0]      wr_value;

  // master: EX stage + table/fetch side
  modport master (
    output ex_valid, ex_pc, ex_taken, ex_target, inv_req, lookup_active,
           rd_valid, rd_tag, rd_cnt,
    input  ex_ready, inv_busy, rd_idx, wr_en, wr_idx, wr_valid, wr_tag,
           wr_cnt, wr_value
  );

  // slave: the update controller
  modport slave (
    input  ex_valid, ex_pc, ex_taken, ex_target, inv_req, lookup_active,
           rd_valid, rd_tag, rd_cnt,
    output ex_ready, inv_busy, rd_idx, wr_en, wr_idx, wr_valid, wr_tag,
           wr_cnt, wr_value
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: queues resolved branches, applies them as tag-checked
// read-modify-write ops, and sweeps the table invalid after reset/request.
module btb_update_ctrl #(
  parameter int ENTRIES = 4,
  parameter int QDEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  btb_update_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int QP_W  = $clog2(QDEPTH);
  localparam int CNT_W = QP_W + 1;

  typedef enum logic [1:0] {INV, IDLE, UPD_RD, UPD_WR} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } br_t;

  state_t           state, state_nxt;
  br_t              q [QDEPTH];
  logic [QP_W-1:0]  head, tail;
  logic [CNT_W-1:0] count;
  logic             push, pop, flush;

  logic [IDX_W-1:0] sweep_idx, op_idx;
  logic [TAG_W-1:0] op_tag;
  logic             op_taken;
  logic [31:0]      op_tgt;
  logic [1:0]       w_cnt;
  logic             hit, upd_go, inv_pend, wr_done;

  assign bus.ex_ready = (count < CNT_W'(QDEPTH)) & (state != INV) & ~bus.inv_req;
  assign push    = bus.ex_valid & bus.ex_ready;
  assign pop     = (state == IDLE) & (count != '0) & ~bus.lookup_active & ~bus.inv_req;
  assign wr_done = (state == UPD_WR) & ~bus.lookup_active;
  // a request seen while a write was pending flushes when that write lands
  assign flush   = (bus.inv_req & (state != INV)) | (wr_done & inv_pend);
  assign hit     = bus.rd_valid & (bus.rd_tag == op_tag);
  assign upd_go  = hit | op_taken;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= INV;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      INV:    if (!bus.lookup_active && sweep_idx == IDX_W'(ENTRIES-1)) state_nxt = IDLE;
      IDLE:   if (bus.inv_req) state_nxt = INV;
              else if (pop)    state_nxt = UPD_RD;
      UPD_RD: if (bus.inv_req)             state_nxt = INV;
              else if (!bus.lookup_active) state_nxt = upd_go ? UPD_WR : IDLE;
      UPD_WR: if (wr_done) state_nxt = (bus.inv_req | inv_pend) ? INV : IDLE;
      default: state_nxt = INV;
    endcase
  end

  always_comb begin
    bus.inv_busy = 1'b0;
    bus.rd_idx   = '0;
    bus.wr_en    = 1'b0;
    bus.wr_idx   = '0;
    bus.wr_valid = 1'b0;
    bus.wr_tag   = '0;
    bus.wr_cnt   = 2'b00;
    bus.wr_value = '0;
    case (state)
      INV: begin
        bus.inv_busy = 1'b1;
        bus.wr_idx   = sweep_idx;
        // outputs stay quiet while reset is held
        if (!rst) begin
          bus.wr_en  = ~bus.lookup_active;
          bus.wr_cnt = 2'b01;
        end
      end
      UPD_RD: bus.rd_idx = op_idx;
      UPD_WR: begin
        bus.rd_idx   = op_idx;
        bus.wr_en    = ~bus.lookup_active;
        bus.wr_idx   = op_idx;
        bus.wr_valid = 1'b1;
        bus.wr_tag   = op_tag;
        bus.wr_cnt   = w_cnt;
        bus.wr_value = op_tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk)
    if (push) q[tail] <= '{pc: bus.ex_pc, taken: bus.ex_taken, tgt: bus.ex_target};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sweep_idx <= '0;
      op_idx    <= '0;
      op_tag    <= '0;
      op_taken  <= 1'b0;
      op_tgt    <= '0;
      w_cnt     <= 2'b00;
      inv_pend  <= 1'b0;
    end else begin
      if (pop) begin
        op_idx   <= q[head].pc[IDX_W+1:2];
        op_tag   <= q[head].pc[31:IDX_W+2];
        op_taken <= q[head].taken;
        op_tgt   <= q[head].tgt;
      end
      if (state == UPD_RD && !bus.inv_req && !bus.lookup_active && upd_go) begin
        if (!hit)          w_cnt <= 2'b10;
        else if (op_taken) w_cnt <= (bus.rd_cnt == 2'b11) ? 2'b11 : bus.rd_cnt + 2'b01;
        else               w_cnt <= (bus.rd_cnt == 2'b00) ? 2'b00 : bus.rd_cnt - 2'b01;
      end
      if (flush)                                   sweep_idx <= '0;
      else if (state == INV && !bus.lookup_active) sweep_idx <= sweep_idx + 1'b1;
      inv_pend <= (state == UPD_WR) & bus.lookup_active & (inv_pend | bus.inv_req);
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl (ENTRIES=4, QDEPTH=4).
module tb_btb_update_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btb_update_ctrl_if #(.ENTRIES(4)) bus();
  btb_update_ctrl #(.ENTRIES(4), .QDEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    bus.ex_valid = 1'b1; bus.ex_pc = pc; bus.ex_taken = tk; bus.ex_target = tg;
    #1 chk("push_rdy", bus.ex_ready, 1);
    step;
    bus.ex_valid = 1'b0;
  endtask

  // accept edge, IDLE cycle, UPD_RD cycle (table data driven here), ends in next cycle
  task automatic to_wr(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic rv, input logic [27:0] rt, input logic [1:0] rc);
    push(pc, tk, tg);
    #1 chk("idle_no_wr", bus.wr_en, 0);
    step;
    bus.rd_valid = rv; bus.rd_tag = rt; bus.rd_cnt = rc;
    #1 chk("rd_idx", bus.rd_idx, pc[3:2]);
    chk("rd_no_wr", bus.wr_en, 0);
    step;
  endtask

  task automatic do_op(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic rv, input logic [27:0] rt, input logic [1:0] rc,
                       input logic exp_wr, input logic [1:0] exp_cnt);
    to_wr(pc, tk, tg, rv, rt, rc);
    #1 chk("op_wr_en", bus.wr_en, exp_wr);
    if (exp_wr) begin
      chk("op_wr_idx", bus.wr_idx, pc[3:2]);
      chk("op_wr_valid", bus.wr_valid, 1);
      chk("op_wr_tag", bus.wr_tag, pc[31:4]);
      chk("op_wr_cnt", bus.wr_cnt, exp_cnt);
      chk("op_wr_value", bus.wr_value, tg);
    end
    step;
    #1 chk("op_back_idle", bus.wr_en, 0);
  endtask

  initial begin
    int nw, extra, ex;
    logic [15:0] pat;
    bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_taken = 0; bus.ex_target = 0;
    bus.inv_req = 0; bus.lookup_active = 0;
    bus.rd_valid = 0; bus.rd_tag = 0; bus.rd_cnt = 0;

    // reset state
    repeat (2) step;
    chk("rst_inv_busy", bus.inv_busy, 1);
    chk("rst_ex_ready", bus.ex_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_rd_idx", bus.rd_idx, 0);
    chk("rst_wr_cnt", bus.wr_cnt, 0);
    chk("rst_wr_value", bus.wr_value, 0);

    // power-up sweep
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("sweep_en", bus.wr_en, 1);
      chk("sweep_idx", bus.wr_idx, i);
      chk("sweep_valid", bus.wr_valid, 0);
      chk("sweep_cnt", bus.wr_cnt, 1);
      step; #1;
    end
    chk("sweep_done_busy", bus.inv_busy, 0);
    chk("sweep_done_rdy", bus.ex_ready, 1);
    chk("sweep_done_en", bus.wr_en, 0);

    // allocate, hit updates, misses
    do_op(32'h48, 1, 32'h100, 0, 28'h0, 2'd0, 1, 2'b10);
    do_op(32'h48, 1, 32'h200, 1, 28'h4, 2'd3, 1, 2'd3);
    do_op(32'h48, 0, 32'h300, 1, 28'h4, 2'd0, 1, 2'd0);
    do_op(32'h48, 1, 32'h400, 1, 28'h4, 2'd1, 1, 2'd2);
    do_op(32'h1234567C, 0, 32'h500, 1, 28'h1234568, 2'd2, 0, 2'd0);
    do_op(32'h1234567C, 0, 32'h600, 1, 28'h1234567, 2'd2, 1, 2'd1);
    do_op(32'h1234567C, 1, 32'h700, 1, 28'h1234566, 2'd0, 1, 2'b10);

    // queue fill under fetch contention, then drain in order
    bus.lookup_active = 1; bus.rd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      bus.ex_valid = 1; bus.ex_pc = i * 4; bus.ex_taken = 1; bus.ex_target = 32'h1000 + i;
      #1 chk("fill_rdy", bus.ex_ready, i < 4);
      step;
    end
    bus.ex_valid = 0; bus.lookup_active = 0;
    nw = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.wr_en) begin
        chk("drain_idx", bus.wr_idx, nw);
        chk("drain_value", bus.wr_value, 32'h1000 + nw);
        nw++;
      end
      step;
    end
    chk("drain_writes", nw, 4);
    chk("drain_rdy", bus.ex_ready, 1);

    // invalidate while an op is in UPD_RD with another queued
    bus.lookup_active = 1;
    push(32'h10, 1, 32'h2000);
    push(32'h14, 1, 32'h2004);
    bus.lookup_active = 0;
    #1 chk("inv_rd_idle", bus.wr_en, 0);
    step;
    bus.inv_req = 1;
    #1 chk("inv_rd_idx", bus.rd_idx, 0);
    chk("inv_rd_rdy", bus.ex_ready, 0);
    chk("inv_rd_en", bus.wr_en, 0);
    step;
    bus.inv_req = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("inv_sweep_en", bus.wr_en, 1);
      chk("inv_sweep_idx", bus.wr_idx, i);
      chk("inv_sweep_valid", bus.wr_valid, 0);
      step; #1;
    end
    chk("inv_done_busy", bus.inv_busy, 0);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.wr_en) extra++;
      step; #1;
    end
    chk("post_sweep_writes", extra, 0);
    chk("post_sweep_rdy", bus.ex_ready, 1);

    // fetch stalls during sweep
    bus.inv_req = 1;
    step;
    bus.inv_req = 0;
    pat = 16'b0000_0010_1101_0110;
    ex = 0;
    for (int c = 0; c < 16 && ex < 4; c++) begin
      bus.lookup_active = pat[c];
      #1 chk("stall_inv_en", bus.wr_en, !pat[c]);
      chk("stall_inv_idx", bus.wr_idx, ex);
      if (!pat[c]) ex++;
      step;
    end
    bus.lookup_active = 0;
    chk("stall_inv_all", ex, 4);
    #1 chk("stall_inv_done", bus.inv_busy, 0);

    // fetch stalls in UPD_WR
    to_wr(32'h2C, 1, 32'h3000, 0, 28'h0, 2'd0);
    bus.lookup_active = 1;
    for (int c = 0; c < 2; c++) begin
      #1 chk("stall_wr_en", bus.wr_en, 0);
      chk("stall_wr_idx", bus.wr_idx, 3);
      chk("stall_wr_cnt", bus.wr_cnt, 2);
      chk("stall_wr_value", bus.wr_value, 32'h3000);
      step;
    end
    bus.lookup_active = 0;
    #1 chk("stall_wr_go", bus.wr_en, 1);
    chk("stall_wr_go_idx", bus.wr_idx, 3);
    chk("stall_wr_go_value", bus.wr_value, 32'h3000);
    step;
    #1 chk("stall_wr_idle", bus.wr_en, 0);

    // invalidate during UPD_WR: pending write lands first
    to_wr(32'h30, 1, 32'h4000, 0, 28'h0, 2'd0);
    bus.lookup_active = 1; bus.inv_req = 1;
    #1 chk("invwr_hold", bus.wr_en, 0);
    step;
    bus.lookup_active = 0;
    #1 chk("invwr_en", bus.wr_en, 1);
    chk("invwr_valid", bus.wr_valid, 1);
    chk("invwr_value", bus.wr_value, 32'h4000);
    step;
    bus.inv_req = 0;
    #1 chk("invwr_to_inv", bus.inv_busy, 1);
    chk("invwr_sweep0", bus.wr_idx, 0);
    chk("invwr_sweep0_valid", bus.wr_valid, 0);
    for (int c = 0; c < 10 && bus.inv_busy; c++) step;
    #1 chk("invwr_done", bus.inv_busy, 0);

    // reset mid-op
    to_wr(32'h34, 1, 32'h5000, 0, 28'h0, 2'd0);
    rst = 1;
    #1 chk("rst_mid_en", bus.wr_en, 0);
    chk("rst_mid_busy", bus.inv_busy, 1);
    step;
    rst = 0;
    #1 chk("rst_mid_sweep_en", bus.wr_en, 1);
    chk("rst_mid_sweep_idx", bus.wr_idx, 0);
    for (int c = 0; c < 10 && bus.inv_busy; c++) step;
    #1 chk("rst_mid_done", bus.inv_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
